// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory request bus and decode-side instruction stream
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC sequencer, fetch FSM and first-word-fall-through instruction buffer
// Optional end-of-program detection on all-zero/unknown words: define IFU_HALT_DETECT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  instruction_fetch_unit_if.master        bus,
  input  logic                            redirect_valid,
  input  logic [31:0]                     redirect_pc,
  output logic                            halted,
  output logic                            fault
);
  localparam int            PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   data_q [FIFO_DEPTH];
  logic [31:0]   data_d [FIFO_DEPTH];
  logic [31:0]   pc_q   [FIFO_DEPTH];
  logic [31:0]   pc_d   [FIFO_DEPTH];
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  logic          head_valid;
  logic          push, pop, flush;
  logic          halt_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

`ifdef IFU_HALT_DETECT_EN
  assign halt_word = (bus.imem_rdata == 32'h0) || ((^bus.imem_rdata) === 1'bx);
`else
  assign halt_word = 1'b0;
`endif

  assign head_valid = (count_q != '0);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = head_valid && bus.inst_ready;

    if (state_q != S_STOP && redirect_valid && redirect_pc[1:0] != 2'b00) begin
      fault_d = 1'b1;
      flush   = 1'b1;
      state_d = S_STOP;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_valid) begin
            flush      = 1'b1;
            fetch_pc_d = redirect_pc;
          end else if (count_q < DEPTH_C) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            flush      = 1'b1;
            fetch_pc_d = redirect_pc;
            state_d    = bus.imem_valid ? S_IDLE : S_DROP;
          end else if (bus.imem_valid) begin
            if (halt_word) begin
              halted_d = 1'b1;
              state_d  = S_STOP;
            end else begin
              push       = 1'b1;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end
          end
        end
        S_DROP: begin
          // FIFO was flushed on entry, so a later redirect only retargets.
          if (redirect_valid) fetch_pc_d = redirect_pc;
          if (bus.imem_valid) state_d = S_IDLE;
        end
        default: ;
      endcase
    end

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    pc_d     = pc_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = bus.imem_rdata;
        pc_d[wr_ptr_q]   = fetch_pc_q;
        wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + ONE_C;
      else if (pop && !push) count_d = count_q - ONE_C;
    end

    // Back-to-back issue only while a free slot can be reserved for the next word.
    if (push && count_d == DEPTH_C) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

  assign bus.imem_req   = (state_q == S_WAIT);
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = head_valid;
  assign bus.inst_data  = head_valid ? data_q[rd_ptr_q] : 32'h0;
  assign bus.inst_pc    = head_valid ? pc_q[rd_ptr_q] : 32'h0;
  assign halted         = halted_q;
  assign fault          = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized fetch/redirect bench against a program-order reference model
`timescale 1ns/1ps
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halted, fault;

  instruction_fetch_unit_if bus_if();

  instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  bit          pending;
  logic [31:0] paddr;
  int          cnt;
  int          lat_fixed = -1;
  bit          halt_at_c = 1'b0;
  logic [31:0] addr_q[$];

  logic [31:0] exp_pc;
  bit          model_stopped;
  bit          model_fault;
  int          n_deliv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    if (a == 32'h8) return 32'h0109_5020;
    if (a == 32'hC && halt_at_c) return 32'h0;
    return ((a * 32'h9E37_79B1) ^ 32'h1357_0000) | 32'h1;
  endfunction

  task automatic mem_drive();
    bus_if.imem_valid = 1'b0;
    bus_if.imem_rdata = $urandom();
    if (!pending && bus_if.imem_req) begin
      pending = 1'b1;
      paddr   = bus_if.imem_addr;
      addr_q.push_back(paddr);
      cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    end else if (pending && cnt > 0) begin
      cnt--;
    end
    if (pending && cnt == 0) begin
      bus_if.imem_valid = 1'b1;
      bus_if.imem_rdata = mem_word(paddr);
      pending = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req",    bus_if.imem_req,   32'h0);
    check_eq("rst_addr",   bus_if.imem_addr,  32'h0);
    check_eq("rst_ivalid", bus_if.inst_valid, 32'h0);
    check_eq("rst_idata",  bus_if.inst_data,  32'h0);
    check_eq("rst_ipc",    bus_if.inst_pc,    32'h0);
    check_eq("rst_halted", halted,            32'h0);
    check_eq("rst_fault",  fault,             32'h0);
    pending = 1'b0;
    bus_if.imem_valid = 1'b0;
    bus_if.inst_ready = 1'b0;
    redirect_valid = 1'b0;
    exp_pc = 32'h0;
    model_stopped = 1'b0;
    model_fault = 1'b0;
    n_deliv = 0;
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: check current outputs, drive inputs for the next edge, advance the model.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    bit flushing;
    @(negedge clk);
    if (pending && bus_if.imem_req) check_eq("addr_stable", bus_if.imem_addr, paddr);
    if (model_stopped) check_eq("req_in_stop", bus_if.imem_req, 32'h0);
    check_eq("fault", fault, model_fault);
    bus_if.inst_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    mem_drive();
    flushing = rv && !model_stopped;
    if (bus_if.inst_valid && rdy && !flushing) begin
      check_eq("inst_pc", bus_if.inst_pc, exp_pc);
      check_eq("inst_data", bus_if.inst_data, mem_word(exp_pc));
      exp_pc += 32'd4;
      n_deliv++;
    end
    if (flushing) begin
      if (rpc[1:0] == 2'b00) exp_pc = rpc;
      else begin
        model_stopped = 1'b1;
        model_fault = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit found;
    bus_if.imem_valid = 1'b0;
    bus_if.imem_rdata = 32'h0;
    bus_if.inst_ready = 1'b0;

    // Sequential fetch, one-cycle memory.
    lat_fixed = 0;
    do_reset();
    @(posedge clk);
    #1;
    check_eq("first_req", bus_if.imem_req, 32'h1);
    check_eq("first_addr", bus_if.imem_addr, 32'h0);
    repeat (6) step(1'b1, 1'b0, 32'h0);
    check_eq("seq_deliv", n_deliv, 32'd5);
    check_eq("seq_naddr", addr_q.size() >= 4, 32'h1);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) check_eq("seq_addr", addr_q[i], 32'(i * 4));

    // Backpressure: two words buffered, then resume at 8.
    do_reset();
    repeat (8) step(1'b0, 1'b0, 32'h0);
    check_eq("bp_issued", addr_q.size(), 32'd2);
    check_eq("bp_req", bus_if.imem_req, 32'h0);
    check_eq("bp_valid", bus_if.inst_valid, 32'h1);
    check_eq("bp_head", bus_if.inst_pc, 32'h0);
    repeat (6) step(1'b1, 1'b0, 32'h0);
    check_eq("bp_nresume", addr_q.size() >= 3, 32'h1);
    if (addr_q.size() >= 3) check_eq("bp_resume", addr_q[2], 32'h8);

    // Redirect while the request for 0x4 is outstanding.
    lat_fixed = 2;
    do_reset();
    for (int i = 0; i < 30 && !(pending && paddr == 32'h4); i++) step(1'b1, 1'b0, 32'h0);
    check_eq("redir_found", pending && paddr == 32'h4, 32'h1);
    step(1'b1, 1'b1, 32'h40);
    base = addr_q.size();
    step(1'b1, 1'b0, 32'h0);
    check_eq("redir_flush", bus_if.inst_valid, 32'h0);
    check_eq("redir_drop_req", bus_if.imem_req, 32'h0);
    base = n_deliv;
    repeat (15) step(1'b1, 1'b0, 32'h0);
    found = 1'b0;
    foreach (addr_q[i]) if (addr_q[i] == 32'h40) found = 1'b1;
    check_eq("redir_addr", found, 32'h1);
    check_eq("redir_progress", n_deliv > base, 32'h1);

    // Misaligned redirect: fault, no more requests, later redirects ignored.
    step(1'b1, 1'b1, 32'h42);
    step(1'b1, 1'b0, 32'h0);
    base = addr_q.size();
    repeat (5) step(1'b1, 1'b1, 32'h80);
    check_eq("stop_noreq", addr_q.size(), base);
    check_eq("stop_empty", bus_if.inst_valid, 32'h0);
    check_eq("stop_fault", fault, 32'h1);

`ifdef IFU_HALT_DETECT_EN
    // Zero word at 0xC ends the program after 0, 4, 8 drain.
    halt_at_c = 1'b1;
    lat_fixed = 0;
    do_reset();
    repeat (12) step(1'b1, 1'b0, 32'h0);
    check_eq("halt_flag", halted, 32'h1);
    check_eq("halt_deliv", n_deliv, 32'd3);
    check_eq("halt_req", bus_if.imem_req, 32'h0);
    check_eq("halt_empty", bus_if.inst_valid, 32'h0);
    halt_at_c = 1'b0;
`endif

    // Wrap at the top of the address space, then reset mid-request.
    lat_fixed = -1;
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 40 && exp_pc != 32'h4; i++) step(1'b1, 1'b0, 32'h0);
    check_eq("wrap_deliv", exp_pc, 32'h4);
    found = 1'b0;
    for (int i = 0; i + 1 < addr_q.size(); i++)
      if (addr_q[i] == 32'hFFFF_FFFC && addr_q[i+1] == 32'h0) found = 1'b1;
    check_eq("wrap_addr", found, 32'h1);
    for (int i = 0; i < 10 && !bus_if.imem_req; i++) step(1'b1, 1'b0, 32'h0);
    check_eq("wrap_inwait", bus_if.imem_req, 32'h1);

    // Randomized traffic: backpressure, redirects (some near wrap), late misaligned redirects.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        int          r;
        rdy = ($urandom % 10) < 7;
        r   = $urandom % 100;
        rv  = 1'b0;
        rpc = $urandom();
        if (r < 4) begin
          rv  = 1'b1;
          rpc = ($urandom % 2) ? ($urandom() & 32'hFFFF_FFFC)
                               : (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4));
        end else if (ph == 3 && cyc > 350 && r == 4) begin
          rv  = 1'b1;
          rpc = $urandom() | 32'h1;
        end
        step(rdy, rv, rpc);
      end
      check_eq("rand_progress", n_deliv >= 20, 32'h1);
      check_eq("rand_halted", halted, 32'h0);
    end

    do_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
